// File: rtl/reg_file_dump_if.sv
// Output word stream of the register-file dump reader: one word plus its register index.
// Out_Valid rises with a captured word and holds it steady until Out_Valid & Out_Ready.
interface reg_file_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Out_Valid;
  logic              Out_Ready;
  logic [DATA_W-1:0] Out_Data;
  logic [ADDR_W-1:0] Out_Idx;

  modport master (output Out_Valid, output Out_Data, output Out_Idx, input Out_Ready);
  modport slave  (input Out_Valid, input Out_Data, input Out_Idx, output Out_Ready);
endinterface

// File: rtl/reg_file_dump.sv
// Walks the register file debug port over START_IDX..END_IDX and streams each word
// out with its index. Reg_Sel is the only combinational output.
module reg_file_dump #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int START_IDX = 0,
  parameter int END_IDX   = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Abort,
  output logic [ADDR_W-1:0] Reg_Sel,
  input  logic [DATA_W-1:0] Reg_Data,
  reg_file_dump_if.master   out_if,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        dbg_state_o
);

  if (START_IDX < 0 || START_IDX > END_IDX || END_IDX >= (1 << ADDR_W)) begin : g_bad_range
    $error("reg_file_dump: need 0 <= START_IDX <= END_IDX < 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(START_IDX);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(END_IDX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEL  = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_idx_q;
  logic              busy_q;
  logic              done_q;
  logic              handshake;

  assign handshake = out_valid_q & out_if.Out_Ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= FIRST_IDX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            state_q <= S_SEL;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b1;
          end
        end
        S_SEL: begin
          if (Abort) begin
            state_q     <= S_IDLE;
            idx_q       <= FIRST_IDX;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            out_data_q  <= Reg_Data;
            out_idx_q   <= idx_q;
            out_valid_q <= 1'b1;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          // Abort takes precedence: a word accepted in the abort cycle is dropped.
          if (Abort) begin
            state_q     <= S_IDLE;
            idx_q       <= FIRST_IDX;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (handshake) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_SEL;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          idx_q   <= FIRST_IDX;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          idx_q       <= FIRST_IDX;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Reg_Sel = '0;
    if (state_q == S_SEL || state_q == S_SEND) Reg_Sel = idx_q;
  end

  assign out_if.Out_Valid = out_valid_q;
  assign out_if.Out_Data  = out_data_q;
  assign out_if.Out_Idx   = out_idx_q;
  assign Busy             = busy_q;
  assign Done             = done_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Bench for reg_file_dump: a pass-level reference model fills an expected-word queue
// on each accepted Start, and a negedge monitor pops it on every accepted word.
module tb_reg_file_dump;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = DW + AW;

  logic clk, rst, Start, Abort;
  logic [AW-1:0] Reg_Sel;
  logic [DW-1:0] Reg_Data;
  logic Busy, Done;
  logic [1:0] dbg_state;

  logic start2, busy2, done2;
  logic [AW-1:0] sel2;
  logic [DW-1:0] data2;
  logic [1:0] dbg_state2;

  logic [DW-1:0] regs [32];

  reg_file_dump_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();
  reg_file_dump_if #(.DATA_W(DW), .ADDR_W(AW)) ifc2 ();

  assign Reg_Data = regs[Reg_Sel];
  assign data2    = regs[sel2];

  reg_file_dump #(.DATA_W(DW), .ADDR_W(AW), .START_IDX(0), .END_IDX(31)) u_dut (
    .clk(clk), .rst(rst), .Start(Start), .Abort(Abort),
    .Reg_Sel(Reg_Sel), .Reg_Data(Reg_Data), .out_if(ifc.master),
    .Busy(Busy), .Done(Done), .dbg_state_o(dbg_state)
  );

  reg_file_dump #(.DATA_W(DW), .ADDR_W(AW), .START_IDX(31), .END_IDX(31)) u_dut_one (
    .clk(clk), .rst(rst), .Start(start2), .Abort(1'b0),
    .Reg_Sel(sel2), .Reg_Data(data2), .out_if(ifc2.master),
    .Busy(busy2), .Done(done2), .dbg_state_o(dbg_state2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;
  bit active = 0;
  bit done_next = 0;
  bit hold = 0;
  logic [W-1:0] hold_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] got, want;
    if (rst) begin
      exp_q.delete();
      active    = 0;
      done_next = 0;
      hold      = 0;
    end else begin
      chk("done_pulse", Done, done_next);
      chk("busy", Busy, active && !done_next);
      if (!active) chk("valid_when_idle", ifc.Out_Valid, 1'b0);
      if (hold) begin
        chk("hold_valid", ifc.Out_Valid, 1'b1);
        chk("hold_word", {ifc.Out_Idx, ifc.Out_Data}, hold_word);
      end
      hold = 0;
      if (Done) done_count++;
      if (done_next) begin
        active    = 0;
        done_next = 0;
      end else if (active) begin
        if (Abort) begin
          exp_q.delete();
          active = 0;
        end else if (ifc.Out_Valid) begin
          got = {ifc.Out_Idx, ifc.Out_Data};
          if (ifc.Out_Ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL extra_word: got 0x%0h, expected no word", got);
            end else begin
              want = exp_q.pop_front();
              chk("word", got, want);
              if (want[W-1 -: AW] == 5'd31) done_next = 1;
            end
          end else begin
            hold      = 1;
            hold_word = got;
          end
        end
      end else if (Start) begin
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), regs[i]});
        active = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_done_random(input string name, input bit spurious);
    int base;
    base = done_count;
    for (int c = 0; c < 3000 && done_count == base; c++) begin
      ifc.Out_Ready = 1'($urandom_range(0, 1));
      Start = spurious && Busy && ($urandom_range(0, 5) == 0);
      step();
    end
    Start = 1'b0;
    ifc.Out_Ready = 1'b1;
    chk(name, done_count, base + 1);
  endtask

  task automatic wait_word(input string name, input logic [AW-1:0] idx, input bit rand_ready);
    bit seen;
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      if (ifc.Out_Valid && ifc.Out_Idx == idx) seen = 1;
      else begin
        ifc.Out_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
      end
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_valid"}, ifc.Out_Valid, 1'b0);
    chk({name, "_data"}, ifc.Out_Data, '0);
    chk({name, "_idx"}, ifc.Out_Idx, '0);
    chk({name, "_sel"}, Reg_Sel, '0);
    chk({name, "_busy"}, Busy, 1'b0);
    chk({name, "_done"}, Done, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int busy_cnt, base, words2, done2_cnt, word_cyc, done_cyc;
    logic [AW-1:0] idx2;
    logic [DW-1:0] dat2;

    rst = 1'b1; Start = 1'b0; Abort = 1'b0; start2 = 1'b0;
    ifc.Out_Ready = 1'b0; ifc2.Out_Ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) step();

    // 1: full pass, ready held high, latency and busy length
    ifc.Out_Ready = 1'b1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("t1_no_valid_in_sel", ifc.Out_Valid, 1'b0);
    busy_cnt = 0;
    for (int c = 0; c < 200 && Busy; c++) begin
      if (c == 1) chk("t1_first_valid_latency", ifc.Out_Valid, 1'b1);
      busy_cnt++;
      step();
    end
    chk("t1_busy_cycles", busy_cnt, 64);
    chk("t1_done_after_last", Done, 1'b1);
    repeat (3) step();

    // 2: random backpressure
    pulse_start();
    wait_done_random("t2_pass_done", 1'b0);
    repeat (3) step();

    // 3: abort in SEND of idx 7 with ready high, then restart
    base = done_count;
    pulse_start();
    wait_word("t3_reach_idx7", 5'd7, 1'b0);
    ifc.Out_Ready = 1'b1;
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("t3_valid_after_abort", ifc.Out_Valid, 1'b0);
    chk("t3_busy_after_abort", Busy, 1'b0);
    repeat (4) step();
    chk("t3_no_done", done_count, base);
    pulse_start();
    wait_done_random("t3_restart_done", 1'b0);
    repeat (3) step();

    // 4: extra Start pulses while busy are ignored
    base = done_count;
    pulse_start();
    wait_done_random("t4_pass_done", 1'b1);
    repeat (12) step();
    chk("t4_single_done", done_count, base + 1);

    // 5: reset in SEND of idx 12
    base = done_count;
    pulse_start();
    wait_word("t5_reach_idx12", 5'd12, 1'b1);
    rst = 1'b1;
    step();
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    repeat (3) step();
    chk("t5_no_done", done_count, base);
    pulse_start();
    wait_done_random("t5_clean_pass", 1'b0);
    repeat (3) step();

    // 6: single-register instance
    regs[31] = 32'hDEAD_BEEF;
    words2 = 0; done2_cnt = 0; word_cyc = -1; done_cyc = -1;
    idx2 = '0; dat2 = '0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ifc2.Out_Valid) begin
        words2++; idx2 = ifc2.Out_Idx; dat2 = ifc2.Out_Data; word_cyc = c;
      end
      if (done2) begin
        done2_cnt++; done_cyc = c;
      end
      step();
    end
    chk("t6_word_count", words2, 1);
    chk("t6_idx", idx2, 5'd31);
    chk("t6_data", dat2, 32'hDEAD_BEEF);
    chk("t6_done_count", done2_cnt, 1);
    chk("t6_done_follows_word", done_cyc, word_cyc + 1);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_done_total", done_count, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
